// File: rtl/jtag_tap_sync.sv
// jtag_tap_sync: JTAG TAP target running entirely on clk_i.
// TCK/TMS/TDI/TRSTn are brought into the clk_i domain with 2-flop
// synchronisers, and TCK edges are found with a third flop. The block has the
// 16-state TAP controller, a 5-bit IR, and the BYPASS, IDCODE and CONFREG
// data registers. confreg_o drives SoC test-mode and boot selection.
module jtag_tap_sync #(
  parameter logic [31:0]       IDCODE_VAL = 32'h249511C3,
  parameter int                IR_W       = 5,
  parameter int                CONF_W     = 9,
  parameter logic [CONF_W-1:0] CONF_RST   = '0
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              jtag_tck_i,
  input  logic              jtag_trst_ni,
  input  logic              jtag_tms_i,
  input  logic              jtag_tdi_i,
  output logic              jtag_tdo_o,
  output logic              jtag_tdo_oe_o,
  output logic [CONF_W-1:0] confreg_o,
  output logic              confreg_upd_o,
  output logic [3:0]        tap_state_o
);

  // TAP state encoding (IEEE 1149.1 style 4-bit codes)
  localparam logic [3:0] TLR    = 4'hF;
  localparam logic [3:0] RTI    = 4'hC;
  localparam logic [3:0] SEL_DR = 4'h7;
  localparam logic [3:0] CAP_DR = 4'h6;
  localparam logic [3:0] SH_DR  = 4'h2;
  localparam logic [3:0] EX1_DR = 4'h1;
  localparam logic [3:0] PAU_DR = 4'h3;
  localparam logic [3:0] EX2_DR = 4'h0;
  localparam logic [3:0] UPD_DR = 4'h5;
  localparam logic [3:0] SEL_IR = 4'h4;
  localparam logic [3:0] CAP_IR = 4'hE;
  localparam logic [3:0] SH_IR  = 4'hA;
  localparam logic [3:0] EX1_IR = 4'h9;
  localparam logic [3:0] PAU_IR = 4'hB;
  localparam logic [3:0] EX2_IR = 4'h8;
  localparam logic [3:0] UPD_IR = 4'hD;

  // Instruction codes. BYPASS (all ones) and every unknown code fall
  // through to the bypass register, so BYPASS needs no explicit compare.
  localparam logic [IR_W-1:0] INS_IDCODE = IR_W'(5'h01);
  localparam logic [IR_W-1:0] INS_CONF   = IR_W'(5'h06);
  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(5'b00101);

  // Synchronisers and edge-detect state
  logic [1:0] r_tck_sync;
  logic       r_tck_prev;
  logic [1:0] r_tms_sync;
  logic [1:0] r_tdi_sync;
  logic [1:0] r_trst_sync;

  logic w_tck_rise;
  logic w_tck_fall;
  logic w_tms;
  logic w_tdi;
  logic w_trst_n;

  // TAP controller and registers
  logic [3:0]        r_state;
  logic [3:0]        w_next;
  logic [IR_W-1:0]   r_ir;
  logic [IR_W-1:0]   r_ir_sh;
  logic [31:0]       r_idcode_sh;
  logic [CONF_W-1:0] r_conf_sh;
  logic              r_bypass;
  logic [CONF_W-1:0] r_confreg;
  logic              r_conf_upd;
  logic              r_tdo;
  logic              r_tdo_oe;

  logic w_sel_idcode;
  logic w_sel_conf;
  logic w_dr_lsb;

  // Synchronise the JTAG pins and keep one extra TCK stage for edge detect.
  // trst sync resets to 0 so the TAP stays held until trst is seen high.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_tck_sync  <= '0;
      r_tck_prev  <= 1'b0;
      r_tms_sync  <= '0;
      r_tdi_sync  <= '0;
      r_trst_sync <= '0;
    end else begin
      r_tck_sync  <= {r_tck_sync[0], jtag_tck_i};
      r_tck_prev  <= r_tck_sync[1];
      r_tms_sync  <= {r_tms_sync[0], jtag_tms_i};
      r_tdi_sync  <= {r_tdi_sync[0], jtag_tdi_i};
      r_trst_sync <= {r_trst_sync[0], jtag_trst_ni};
    end
  end

  // TMS/TDI come from the same sync stage as TCK, so they line up with the edge
  assign w_tck_rise = r_tck_sync[1] & ~r_tck_prev;
  assign w_tck_fall = ~r_tck_sync[1] & r_tck_prev;
  assign w_tms      = r_tms_sync[1];
  assign w_tdi      = r_tdi_sync[1];
  assign w_trst_n   = r_trst_sync[1];

  assign w_sel_idcode = (r_ir == INS_IDCODE);
  assign w_sel_conf   = (r_ir == INS_CONF);

  // TAP next-state function
  always_comb begin
    w_next = r_state;
    case (r_state)
      TLR:     w_next = w_tms ? TLR    : RTI;
      RTI:     w_next = w_tms ? SEL_DR : RTI;
      SEL_DR:  w_next = w_tms ? SEL_IR : CAP_DR;
      CAP_DR:  w_next = w_tms ? EX1_DR : SH_DR;
      SH_DR:   w_next = w_tms ? EX1_DR : SH_DR;
      EX1_DR:  w_next = w_tms ? UPD_DR : PAU_DR;
      PAU_DR:  w_next = w_tms ? EX2_DR : PAU_DR;
      EX2_DR:  w_next = w_tms ? UPD_DR : SH_DR;
      UPD_DR:  w_next = w_tms ? SEL_DR : RTI;
      SEL_IR:  w_next = w_tms ? TLR    : CAP_IR;
      CAP_IR:  w_next = w_tms ? EX1_IR : SH_IR;
      SH_IR:   w_next = w_tms ? EX1_IR : SH_IR;
      EX1_IR:  w_next = w_tms ? UPD_IR : PAU_IR;
      PAU_IR:  w_next = w_tms ? EX2_IR : PAU_IR;
      EX2_IR:  w_next = w_tms ? UPD_IR : SH_IR;
      UPD_IR:  w_next = w_tms ? SEL_DR : RTI;
      default: w_next = TLR;
    endcase
  end

  // State register: advances on each detected TCK rise; trst forces TLR
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= TLR;
    end else if (!w_trst_n) begin
      r_state <= TLR;
    end else if (w_tck_rise) begin
      r_state <= w_next;
    end
  end

  // Instruction path: capture, shift LSB-first, update; entering TLR selects IDCODE
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_ir    <= INS_IDCODE;
      r_ir_sh <= '0;
    end else if (!w_trst_n) begin
      r_ir    <= INS_IDCODE;
      r_ir_sh <= '0;
    end else if (w_tck_rise) begin
      case (r_state)
        CAP_IR:  r_ir_sh <= IR_CAPTURE;
        SH_IR:   r_ir_sh <= {w_tdi, r_ir_sh[IR_W-1:1]};
        UPD_IR:  r_ir    <= r_ir_sh;
        default: ;
      endcase
      if (w_next == TLR) r_ir <= INS_IDCODE;
    end
  end

  // Data registers: only the register selected by IR captures and shifts,
  // so PAUSE holds contents and EX2 -> SH resumes without recapture
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_idcode_sh <= '0;
      r_conf_sh   <= '0;
      r_bypass    <= 1'b0;
    end else if (!w_trst_n) begin
      r_idcode_sh <= '0;
      r_conf_sh   <= '0;
      r_bypass    <= 1'b0;
    end else if (w_tck_rise) begin
      if (r_state == CAP_DR) begin
        if (w_sel_idcode)      r_idcode_sh <= IDCODE_VAL;
        else if (w_sel_conf)   r_conf_sh   <= r_confreg;
        else                   r_bypass    <= 1'b0;
      end else if (r_state == SH_DR) begin
        if (w_sel_idcode)      r_idcode_sh <= {w_tdi, r_idcode_sh[31:1]};
        else if (w_sel_conf)   r_conf_sh   <= {w_tdi, r_conf_sh[CONF_W-1:1]};
        else                   r_bypass    <= w_tdi;
      end
    end
  end

  // CONFREG update with a single-cycle strobe; TLR leaves it alone
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_confreg  <= CONF_RST;
      r_conf_upd <= 1'b0;
    end else if (!w_trst_n) begin
      r_confreg  <= CONF_RST;
      r_conf_upd <= 1'b0;
    end else begin
      r_conf_upd <= 1'b0;
      if (w_tck_rise && (r_state == UPD_DR) && w_sel_conf) begin
        r_confreg  <= r_conf_sh;
        r_conf_upd <= 1'b1;
      end
    end
  end

  // LSB of whichever data register is currently selected
  assign w_dr_lsb = w_sel_idcode ? r_idcode_sh[0] :
                    w_sel_conf   ? r_conf_sh[0]   : r_bypass;

  // TDO and its enable change only on TCK fall; outside shift states TDO holds
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_tdo    <= 1'b0;
      r_tdo_oe <= 1'b0;
    end else if (!w_trst_n) begin
      r_tdo    <= 1'b0;
      r_tdo_oe <= 1'b0;
    end else if (w_tck_fall) begin
      if (r_state == SH_IR)      r_tdo <= r_ir_sh[0];
      else if (r_state == SH_DR) r_tdo <= w_dr_lsb;
      r_tdo_oe <= (r_state == SH_IR) || (r_state == SH_DR);
    end
  end

  assign jtag_tdo_o    = r_tdo;
  assign jtag_tdo_oe_o = r_tdo_oe;
  assign confreg_o     = r_confreg;
  assign confreg_upd_o = r_conf_upd;
  assign tap_state_o   = r_state;

endmodule
